// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath constants: condition-code encodings and default sizes.
package lc3_pkg;

  localparam int unsigned LC3_DATA_W   = 16;
  localparam int unsigned LC3_NUM_REGS = 8;

  typedef logic [2:0] cc_t;

  localparam cc_t CC_N     = 3'b100;
  localparam cc_t CC_Z     = 3'b010;
  localparam cc_t CC_P     = 3'b001;
  localparam cc_t CC_RESET = CC_Z;

  // Classify a result from its sign bit and zero test; the result is always one-hot.
  function automatic cc_t cc_classify(input logic sign, input logic zero);
    if (sign) begin
      return CC_N;
    end else if (zero) begin
      return CC_Z;
    end else begin
      return CC_P;
    end
  endfunction

endpackage

// File: rtl/lc3_regfile_sb_if.sv
// Decode/writeback bus into the LC-3 register file and scoreboard.
interface lc3_regfile_sb_if
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W   = LC3_DATA_W,
  parameter int unsigned NUM_REGS = LC3_NUM_REGS,
  parameter int unsigned NUM_RD   = 2
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  // Writeback side
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     cc_en;
  // Decode side
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     issue_ok;
  // Status
  logic [NUM_REGS-1:0]      pend_vec;
  cc_t                      cc_nzp;
  logic                     err;

  modport master (
    output wr_en, wr_addr, wr_data, cc_en, rd_addr, issue_en, issue_addr,
    input  rd_data, rd_busy, issue_ok, pend_vec, cc_nzp, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, cc_en, rd_addr, issue_en, issue_addr,
    output rd_data, rd_busy, issue_ok, pend_vec, cc_nzp, err
  );

endinterface

// File: rtl/lc3_scoreboard.sv
// Per-register pending-write scoreboard with issue legality and sticky error flag.
module lc3_scoreboard #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic                issue_en_i,
  input  logic [ADDR_W-1:0]   issue_addr_i,
  output logic                issue_ok_o,
  output logic [NUM_REGS-1:0] pend_vec_o,
  output logic                err_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                err_q, err_d;

  // A claim is legal if the register is free or is being released this very cycle.
  always_comb begin
    issue_ok_o = rst || !pend_q[issue_addr_i] ||
                 (wr_en_i && (wr_addr_i == issue_addr_i));
  end

  // Clear on writeback first, then a legal claim sets, so a same-address claim wins.
  always_comb begin
    pend_d = pend_q;
    err_d  = err_q;
    if (wr_en_i) begin
      pend_d[wr_addr_i] = 1'b0;
    end
    if (issue_en_i) begin
      if (issue_ok_o) begin
        pend_d[issue_addr_i] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Scoreboard and error state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign pend_vec_o = pend_q;
  assign err_o      = err_q;

endmodule

// File: rtl/lc3_regfile_sb.sv
// LC-3 register file: multi-port reads with optional write bypass, scoreboard, NZP codes.
module lc3_regfile_sb
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W   = LC3_DATA_W,
  parameter int unsigned NUM_REGS = LC3_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1
) (
  input logic              clk,
  input logic              rst,
  lc3_regfile_sb_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  cc_t                      cc_q, cc_d;
  logic                     wr_commit;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;
  logic [ADDR_W-1:0]        rd_sel;
  logic                     rd_hit;

  assign wr_commit = bus.wr_en && !rst;

  // Register storage; writeback commits on the edge, reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Next condition codes: only a committing write with cc_en reclassifies.
  always_comb begin
    cc_d = cc_q;
    if (bus.wr_en && bus.cc_en) begin
      cc_d = cc_classify(bus.wr_data[DATA_W-1], bus.wr_data == '0);
    end
  end

  // Condition-code register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  // Read ports: a bypass hit forwards write data and masks the busy flag; reset reads as idle.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    rd_sel    = '0;
    rd_hit    = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_sel = bus.rd_addr[k*ADDR_W +: ADDR_W];
      rd_hit = (BYPASS != 0) && wr_commit && (bus.wr_addr == rd_sel);
      if (!rst) begin
        rd_data_c[k*DATA_W +: DATA_W] = rd_hit ? bus.wr_data : regs_q[rd_sel];
        rd_busy_c[k]                  = bus.pend_vec[rd_sel] && !rd_hit;
      end
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;
  assign bus.cc_nzp  = cc_q;

  lc3_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (bus.wr_en),
    .wr_addr_i    (bus.wr_addr),
    .issue_en_i   (bus.issue_en),
    .issue_addr_i (bus.issue_addr),
    .issue_ok_o   (bus.issue_ok),
    .pend_vec_o   (bus.pend_vec),
    .err_o        (bus.err)
  );

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Directed, table-driven bench for lc3_regfile_sb with BYPASS=1 and BYPASS=0 instances.
module tb_lc3_regfile_sb;

  typedef struct packed {
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cc_en;
    logic [2:0]  rd0;
    logic [2:0]  rd1;
    logic        issue_en;
    logic [2:0]  issue_addr;
  } in_t;

  typedef struct packed {
    logic [15:0] rd0;
    logic [15:0] rd1;
    logic [1:0]  busy;
    logic        ok;
    logic [7:0]  pend;
    logic [2:0]  cc;
    logic        err;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl [16];

  always #5 clk = ~clk;

  lc3_regfile_sb_if #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2)) bus1 ();
  lc3_regfile_sb_if #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2)) bus0 ();

  lc3_regfile_sb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .BYPASS(1))
    dut_byp (.clk(clk), .rst(rst), .bus(bus1));
  lc3_regfile_sb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .BYPASS(0))
    dut_nobyp (.clk(clk), .rst(rst), .bus(bus0));

  function automatic in_t mk_in(logic r, logic we, logic [2:0] wa, logic [15:0] wd, logic ce,
                                logic [2:0] a0, logic [2:0] a1, logic ie, logic [2:0] ia);
    in_t v;
    v = '{r, we, wa, wd, ce, a0, a1, ie, ia};
    return v;
  endfunction

  function automatic out_t mk_out(logic [15:0] d0, logic [15:0] d1, logic [1:0] b, logic ok,
                                  logic [7:0] p, logic [2:0] cc, logic e);
    out_t v;
    v = '{d0, d1, b, ok, p, cc, e};
    return v;
  endfunction

  function automatic out_t get1();
    return mk_out(bus1.rd_data[15:0], bus1.rd_data[31:16], bus1.rd_busy, bus1.issue_ok,
                  bus1.pend_vec, bus1.cc_nzp, bus1.err);
  endfunction

  function automatic out_t get0();
    return mk_out(bus0.rd_data[15:0], bus0.rd_data[31:16], bus0.rd_busy, bus0.issue_ok,
                  bus0.pend_vec, bus0.cc_nzp, bus0.err);
  endfunction

  task automatic apply(input in_t v);
    rst             = v.rst;
    bus1.wr_en      = v.wr_en;      bus0.wr_en      = v.wr_en;
    bus1.wr_addr    = v.wr_addr;    bus0.wr_addr    = v.wr_addr;
    bus1.wr_data    = v.wr_data;    bus0.wr_data    = v.wr_data;
    bus1.cc_en      = v.cc_en;      bus0.cc_en      = v.cc_en;
    bus1.rd_addr    = {v.rd1, v.rd0}; bus0.rd_addr  = {v.rd1, v.rd0};
    bus1.issue_en   = v.issue_en;   bus0.issue_en   = v.issue_en;
    bus1.issue_addr = v.issue_addr; bus0.issue_addr = v.issue_addr;
  endtask

  task automatic chk(input string nm, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rd0=%h rd1=%h busy=%b ok=%b pend=%h cc=%b err=%b ; want rd0=%h rd1=%h busy=%b ok=%b pend=%h cc=%b err=%b",
               nm, act.rd0, act.rd1, act.busy, act.ok, act.pend, act.cc, act.err,
               exp.rd0, exp.rd1, exp.busy, exp.ok, exp.pend, exp.cc, exp.err);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 time units later, well before the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Hand-computed vectors; each row's expected outputs reflect state before that row's rising edge.
    tbl[0]  = '{mk_in(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0), mk_out(16'h0000, 16'h0000, 2'b00, 1, 8'h00, 3'b010, 0)};
    tbl[1]  = '{mk_in(0, 1, 3, 16'h8001, 1, 3, 0, 0, 0), mk_out(16'h8001, 16'h0000, 2'b00, 1, 8'h00, 3'b010, 0)};
    tbl[2]  = '{mk_in(0, 1, 4, 16'h0005, 0, 3, 4, 0, 0), mk_out(16'h8001, 16'h0005, 2'b00, 1, 8'h00, 3'b100, 0)};
    tbl[3]  = '{mk_in(0, 0, 0, 16'h0000, 1, 4, 3, 0, 0), mk_out(16'h0005, 16'h8001, 2'b00, 1, 8'h00, 3'b100, 0)};
    tbl[4]  = '{mk_in(0, 0, 0, 16'h0000, 0, 5, 4, 1, 5), mk_out(16'h0000, 16'h0005, 2'b00, 1, 8'h00, 3'b100, 0)};
    tbl[5]  = '{mk_in(0, 0, 0, 16'h0000, 0, 5, 5, 1, 5), mk_out(16'h0000, 16'h0000, 2'b11, 0, 8'h20, 3'b100, 0)};
    tbl[6]  = '{mk_in(0, 1, 5, 16'h0000, 1, 5, 4, 0, 5), mk_out(16'h0000, 16'h0005, 2'b00, 1, 8'h20, 3'b100, 1)};
    tbl[7]  = '{mk_in(0, 0, 0, 16'h0000, 0, 5, 0, 0, 5), mk_out(16'h0000, 16'h0000, 2'b00, 1, 8'h00, 3'b010, 1)};
    tbl[8]  = '{mk_in(0, 0, 0, 16'h0000, 0, 6, 0, 1, 6), mk_out(16'h0000, 16'h0000, 2'b00, 1, 8'h00, 3'b010, 1)};
    tbl[9]  = '{mk_in(0, 1, 6, 16'h7FFF, 1, 6, 6, 1, 6), mk_out(16'h7FFF, 16'h7FFF, 2'b00, 1, 8'h40, 3'b010, 1)};
    tbl[10] = '{mk_in(0, 0, 0, 16'h0000, 0, 6, 6, 0, 6), mk_out(16'h7FFF, 16'h7FFF, 2'b11, 0, 8'h40, 3'b001, 1)};
    tbl[11] = '{mk_in(0, 0, 0, 16'h0000, 0, 1, 7, 1, 1), mk_out(16'h0000, 16'h0000, 2'b00, 1, 8'h40, 3'b001, 1)};
    tbl[12] = '{mk_in(0, 0, 0, 16'h0000, 0, 1, 7, 1, 7), mk_out(16'h0000, 16'h0000, 2'b01, 1, 8'h42, 3'b001, 1)};
    tbl[13] = '{mk_in(1, 1, 1, 16'hFFFF, 1, 1, 6, 1, 2), mk_out(16'h0000, 16'h0000, 2'b00, 1, 8'hC2, 3'b001, 1)};
    tbl[14] = '{mk_in(0, 0, 0, 16'h0000, 0, 1, 6, 0, 2), mk_out(16'h0000, 16'h0000, 2'b00, 1, 8'h00, 3'b010, 0)};
    tbl[15] = '{mk_in(0, 1, 7, 16'h0001, 1, 7, 1, 0, 2), mk_out(16'h0001, 16'h0000, 2'b00, 1, 8'h00, 3'b010, 0)};

    // Initial reset: two rising edges with rst high.
    apply(mk_in(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    // After reset every register reads zero on both ports.
    for (int r = 0; r < 8; r++) begin
      apply(mk_in(0, 0, 0, 16'h0000, 0, 3'(r), 3'(7 - r), 0, 0));
      #2;
      chk($sformatf("reset_read_r%0d", r), get1(),
          mk_out(16'h0000, 16'h0000, 2'b00, 1, 8'h00, 3'b010, 0));
      next_cycle();
    end

    // Main directed table on the bypassing instance.
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].i);
      #2;
      chk($sformatf("vec%0d", i), get1(), tbl[i].o);
      next_cycle();
    end

    // State now: R7=0001, all others 0, pend=0, cc=001, err=0 in both instances.
    // Claim R2 so that the non-bypassing instance shows raw busy during writeback.
    apply(mk_in(0, 0, 0, 16'h0000, 0, 2, 7, 1, 2));
    #2;
    chk("claim_r2_byp", get1(), mk_out(16'h0000, 16'h0001, 2'b00, 1, 8'h00, 3'b001, 0));
    next_cycle();

    // Writeback R2 while port0 reads R2: forwarded on one instance, stale on the other.
    apply(mk_in(0, 1, 2, 16'h1234, 0, 2, 7, 0, 2));
    #2;
    chk("wb_r2_byp",   get1(), mk_out(16'h1234, 16'h0001, 2'b00, 1, 8'h04, 3'b001, 0));
    chk("wb_r2_nobyp", get0(), mk_out(16'h0000, 16'h0001, 2'b01, 1, 8'h04, 3'b001, 0));
    next_cycle();

    // One cycle later both instances see the committed value and the claim released.
    apply(mk_in(0, 0, 0, 16'h0000, 0, 2, 2, 0, 2));
    #2;
    chk("after_r2_byp",   get1(), mk_out(16'h1234, 16'h1234, 2'b00, 1, 8'h00, 3'b001, 0));
    chk("after_r2_nobyp", get0(), mk_out(16'h1234, 16'h1234, 2'b00, 1, 8'h00, 3'b001, 0));
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
